// File: rtl/ast_dmx_dir_sched_if.sv
// Handshake/framing bundle between the packet source, the direction scheduler
// and ast_dmx. The scheduler uses the slave modport; the source/sink side of
// the bench or the surrounding fabric uses the master modport.
interface ast_dmx_dir_sched_if #(
    parameter int DIR_SEL_WIDTH = 2
);
    logic                     ast_valid_i;
    logic                     ast_startofpacket_i;
    logic                     ast_endofpacket_i;
    logic                     ast_ready_o;
    logic                     ast_valid_o;
    logic                     ast_ready_i;
    logic [DIR_SEL_WIDTH-1:0] dir_o;

    modport slave (
        input  ast_valid_i,
        input  ast_startofpacket_i,
        input  ast_endofpacket_i,
        input  ast_ready_i,
        output ast_ready_o,
        output ast_valid_o,
        output dir_o
    );

    modport master (
        output ast_valid_i,
        output ast_startofpacket_i,
        output ast_endofpacket_i,
        output ast_ready_i,
        input  ast_ready_o,
        input  ast_valid_o,
        input  dir_o
    );
endinterface

// File: rtl/ast_dmx_dir_sched.sv
// Packet-level direction scheduler in front of ast_dmx.
// Chooses an output direction per packet among enabled directions that still
// have credit, holds it for the whole packet and gates the source handshake.
// Data/empty/channel bypass this block entirely.
//
// Build option: AST_DMX_SCHED_STRICT_PRIO_EN
//   defined   -> lowest-index eligible direction wins, no round-robin pointer
//   undefined -> round-robin starting after the last granted direction
//
// state  | meaning
// SELECT | waiting for a sop; dir_o follows the live candidate
// PACKET | packet in flight; dir_o frozen on cur_dir, handshake passes through
module ast_dmx_dir_sched #(
    parameter int TX_DIR          = 4,
    parameter int DIR_SEL_WIDTH   = (TX_DIR == 1) ? 1 : $clog2(TX_DIR),
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [TX_DIR-1:0]    dir_en_i,
    input  logic [TX_DIR-1:0]    pkt_done_i,
    ast_dmx_dir_sched_if.slave   ast,
    output logic                 busy_o,
    output logic                 protocol_err_o
);

    typedef enum logic [0:0] {
        SELECT = 1'b0,
        PACKET = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    state_t                   state_q, state_d;
    logic [DIR_SEL_WIDTH-1:0] cur_dir_q, cur_dir_d;
    logic [CNT_WIDTH-1:0]     cnt_q [TX_DIR];
    logic [CNT_WIDTH-1:0]     cnt_d [TX_DIR];

    logic [TX_DIR-1:0]        elig;
    logic                     grant;
    logic [DIR_SEL_WIDTH-1:0] cand;
    logic                     inc_en;
    logic [DIR_SEL_WIDTH-1:0] inc_sel;
    logic                     fsm_err;
    logic                     underflow_err;

`ifdef AST_DMX_SCHED_STRICT_PRIO_EN
    // Fixed priority: the lowest-index eligible direction wins.
    always_comb begin
        cand = '0;
        for (int i = TX_DIR - 1; i >= 0; i--) begin
            if (elig[DIR_SEL_WIDTH'(i)]) begin
                cand = DIR_SEL_WIDTH'(i);
            end
        end
    end
`else
    localparam logic [DIR_SEL_WIDTH-1:0] LAST_DIR = DIR_SEL_WIDTH'(TX_DIR - 1);

    logic [DIR_SEL_WIDTH-1:0] rr_last_q, rr_last_d;

    // Round-robin search starting one past the last granted direction.
    always_comb begin
        logic found;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < TX_DIR; i++) begin
            int                       idx;
            logic [DIR_SEL_WIDTH-1:0] ix;
            idx = (int'(rr_last_q) + 1 + i) % TX_DIR;
            ix  = DIR_SEL_WIDTH'(idx);
            if (!found && elig[ix]) begin
                found = 1'b1;
                cand  = ix;
            end
        end
    end

    // Round-robin pointer; only moves when a sop is actually accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_last_q <= LAST_DIR;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    // Pointer follows the direction latched at sop acceptance.
    always_comb begin
        rr_last_d = rr_last_q;
        if (state_q == SELECT && state_d == PACKET) begin
            rr_last_d = cand;
        end else if (state_q == SELECT && inc_en) begin
            rr_last_d = cand;
        end
    end
`endif

    // A direction is eligible when enabled and below its outstanding limit.
    always_comb begin
        for (int d = 0; d < TX_DIR; d++) begin
            elig[d] = dir_en_i[d] && (cnt_q[d] < CNT_MAX);
        end
    end

    assign grant = |elig;

    // FSM state, latched direction and credit counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SELECT;
            cur_dir_q <= '0;
            for (int d = 0; d < TX_DIR; d++) begin
                cnt_q[d] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            for (int d = 0; d < TX_DIR; d++) begin
                cnt_q[d] <= cnt_d[d];
            end
        end
    end

    // Next-state, handshake gating and direction output.
    always_comb begin
        state_d         = state_q;
        cur_dir_d       = cur_dir_q;
        inc_en          = 1'b0;
        inc_sel         = cur_dir_q;
        fsm_err         = 1'b0;
        ast.ast_ready_o = 1'b0;
        ast.ast_valid_o = 1'b0;
        ast.dir_o       = cur_dir_q;

        case (state_q)
            SELECT: begin
                ast.dir_o = cand;
                if (ast.ast_valid_i && !ast.ast_startofpacket_i) begin
                    // Orphan beat outside a packet: swallow it so the source
                    // cannot wedge, and flag it.
                    ast.ast_ready_o = 1'b1;
                    fsm_err         = 1'b1;
                end else begin
                    ast.ast_valid_o = ast.ast_valid_i && grant;
                    ast.ast_ready_o = ast.ast_ready_i && grant;
                    if (ast.ast_valid_i && grant && ast.ast_ready_i) begin
                        cur_dir_d = cand;
                        if (ast.ast_endofpacket_i) begin
                            inc_en  = 1'b1;
                            inc_sel = cand;
                        end else begin
                            state_d = PACKET;
                        end
                    end
                end
            end
            PACKET: begin
                ast.ast_valid_o = ast.ast_valid_i;
                ast.ast_ready_o = ast.ast_ready_i;
                if (ast.ast_valid_i && ast.ast_ready_i) begin
                    // A nested sop is passed along as data; framing is flagged.
                    if (ast.ast_startofpacket_i) begin
                        fsm_err = 1'b1;
                    end
                    if (ast.ast_endofpacket_i) begin
                        inc_en  = 1'b1;
                        state_d = SELECT;
                    end
                end
            end
            default: begin
                state_d = SELECT;
            end
        endcase

        if (rst_i) begin
            ast.ast_ready_o = 1'b0;
            ast.ast_valid_o = 1'b0;
            ast.dir_o       = '0;
        end
    end

    // Credit update: +1 on packet completion here, -1 on downstream release.
    // A release against an empty counter is ignored and reported.
    always_comb begin
        underflow_err = 1'b0;
        for (int d = 0; d < TX_DIR; d++) begin
            logic inc;
            logic dec;
            inc   = inc_en && (inc_sel == DIR_SEL_WIDTH'(d));
            dec   = pkt_done_i[d] && (cnt_q[d] != '0);
            if (pkt_done_i[d] && (cnt_q[d] == '0)) begin
                underflow_err = 1'b1;
            end
            cnt_d[d] = cnt_q[d];
            if (inc && !dec) begin
                cnt_d[d] = cnt_q[d] + CNT_WIDTH'(1);
            end else if (dec && !inc) begin
                cnt_d[d] = cnt_q[d] - CNT_WIDTH'(1);
            end
        end
    end

    // Status outputs, held low while reset is asserted.
    always_comb begin
        busy_o         = !rst_i && (state_q == PACKET);
        protocol_err_o = !rst_i && (fsm_err || underflow_err);
    end

endmodule

// File: doc/ast_dmx_dir_sched.md
Name: ast_dmx_dir_sched

Overview:
- Packet-level direction scheduler placed in front of ast_dmx. Drives ast_dmx dir_i and gates the source valid/ready handshake.
- Data, empty and channel go straight from the source to ast_dmx. This block handles only the handshake and packet framing.
- Picks an output direction per packet, round-robin over enabled directions that still have credit. Keeps the direction stable for the whole packet.
- Tracks outstanding packets per direction against MAX_OUTSTANDING. Credit is returned by downstream pkt_done_i pulses.

Parameters:
TX_DIR, 4, number of ast_dmx output directions (1..16)
DIR_SEL_WIDTH, TX_DIR==1 ? 1 : $clog2(TX_DIR), width of dir_o
MAX_OUTSTANDING, 4, max packets in flight per direction (>=1)
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), per-direction counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
dir_en_i  in  TX_DIR  per-direction enable mask
pkt_done_i  in  TX_DIR  one-cycle pulse: consumer on dir d released one packet
ast_valid_i  in  1  source valid
ast_startofpacket_i  in  1  source sop
ast_endofpacket_i  in  1  source eop
ast_ready_o  out  1  ready to source
ast_valid_o  out  1  valid to ast_dmx
ast_ready_i  in  1  ready from ast_dmx
dir_o  out  DIR_SEL_WIDTH  direction to ast_dmx dir_i
busy_o  out  1  high in PACKET state
protocol_err_o  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync release):
  - state=SELECT, all counters 0, rr_last=TX_DIR-1, cur_dir=0.
  - While rst_i is high: ast_ready_o=0, ast_valid_o=0, dir_o=0, busy_o=0, protocol_err_o=0.
- Eligibility and candidate:
  - elig[d] = dir_en_i[d] & (cnt[d] < MAX_OUTSTANDING).
  - cand = first d with elig[d]=1, searching circularly from rr_last+1. Combinational.
- SELECT state:
  - dir_o=cand.
  - grant = |elig.
  - sop beat: ast_valid_o = ast_valid_i & grant; ast_ready_o = ast_ready_i & grant. Zero-cycle combinational path.
  - Non-sop beat (valid & !sop): dropped. ast_ready_o=1, ast_valid_o=0, protocol_err_o=1 for that cycle.
- SELECT, sop accepted (ast_valid_o & ast_ready_i):
  - cur_dir<=cand, rr_last<=cand.
  - If eop is also high (single beat): cnt[cand]++ and stay in SELECT.
  - Otherwise go to PACKET.
- PACKET state:
  - dir_o=cur_dir (registered, stable).
  - ast_valid_o=ast_valid_i, ast_ready_o=ast_ready_i. No gating.
  - Eop accepted: cnt[cur_dir]++, go to SELECT.
  - Sop accepted in PACKET: forwarded as a normal beat, protocol_err_o=1, no state change.
- Counters:
  - Per direction: +1 on eop acceptance, −1 on pkt_done_i[d].
  - Both in the same cycle: unchanged.
  - pkt_done_i at 0: ignored (no underflow), protocol_err_o=1.
  - Increment at MAX_OUTSTANDING cannot occur, because selection requires cnt<MAX.
  - Updates are visible in elig the next cycle.
- dir_en_i change:
  - Mid-packet: no effect; the packet completes on cur_dir.
  - Affects only the next selection.
  - All directions disabled or full: sop is stalled (ast_ready_o=0) until one becomes eligible.
- Backpressure: ast_ready_i=0 holds all state. In SELECT, cand may change between cycles while sop is stalled. Only the value at acceptance is latched.
- rst_i asserted mid-packet: immediately returns to reset state. Downstream packet truncation is the system's responsibility.

Optional Feature:
AST_DMX_SCHED_STRICT_PRIO_EN
- Defined: cand = lowest-index eligible direction, and rr_last is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, dir_en_i=4'b1111, four 3-beat packets, ast_ready_i=1 -> dir_o at each sop = 0,1,2,3; cnt=1 each; busy_o high beats 1-2 of each packet.
- MAX_OUTSTANDING=4, dir_en_i=4'b0001, no pkt_done -> packets 1-4 pass; 5th sop sees ast_ready_o=0. Pulse pkt_done_i[0] -> 5th sop accepted the cycle after.
- dir_en_i=4'b1010, single-beat packets -> directions alternate 1,3,1,3; dirs 0 and 2 never chosen.
- Mid-packet: dir_en_i drops bit cur_dir, ast_ready_i toggled 1010 -> dir_o constant until eop; next packet goes to the next enabled direction.
- Non-sop beat in SELECT -> ast_ready_o=1, ast_valid_o=0, protocol_err_o pulse; pkt_done_i[2] with cnt[2]=0 -> cnt stays 0, error pulse.
- STRICT_PRIO build, dir_en_i=4'b0110 -> every packet goes to dir 1 until cnt[1]=4, then dir 2.
